// File: rtl/motor_pwm_driver_pkg.sv
// Purpose: shared defaults and ramp arithmetic for the motor PWM driver.
// Contents: default parameter values, sat_ramp() saturating add/subtract.
package motor_drv_pkg;

    localparam int unsigned PWM_BITS_DEF  = 8;
    localparam int unsigned RAMP_DIV_DEF  = 16;
    localparam int unsigned RAMP_STEP_DEF = 8;
    localparam int unsigned DUTY_MAX_DEF  = 255;

    // Working width for ramp arithmetic; much wider than any duty, so neither direction wraps
    localparam int unsigned SAT_W = 32;

    // One ramp step: up saturates at max_v, down saturates at 0
    function automatic logic [SAT_W-1:0] sat_ramp(
        input logic [SAT_W-1:0] duty,
        input logic             up,
        input logic [SAT_W-1:0] step,
        input logic [SAT_W-1:0] max_v
    );
        logic [SAT_W-1:0] sum;
        sum = duty + step;
        if (up) begin
            return (sum > max_v) ? max_v : sum;
        end
        return (duty >= step) ? (duty - step) : '0;
    endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Purpose: command/drive bundle between the navigation FSM and the motor PWM driver.
// master: navigation side (drives motor commands, observes drive/status).
// slave : driver side (reads commands, drives pwm, duty and brake).
interface motor_pwm_driver_if #(
    parameter int unsigned PWM_BITS = 8
);
    logic                motorLeft;
    logic                motorRight;
    logic                pwmLeft;
    logic                pwmRight;
    logic [PWM_BITS-1:0] dutyLeft;
    logic [PWM_BITS-1:0] dutyRight;
    logic                brake;

    modport master (
        output motorLeft, motorRight,
        input  pwmLeft, pwmRight, dutyLeft, dutyRight, brake
    );

    modport slave (
        input  motorLeft, motorRight,
        output pwmLeft, pwmRight, dutyLeft, dutyRight, brake
    );
endinterface

// File: rtl/motor_pwm_driver_channel.sv
// Purpose: one wheel channel - duty ramp register, period shadow, PWM compare flop.
// Ports: clk, reset (sync, active-high), cmd_i run/stop, tick_i ramp strobe,
//        cnt_i shared PWM counter, period_end_i (cnt at max), pwm_o drive, duty_o ramp duty.
module pwm_channel
    import motor_drv_pkg::*;
#(
    parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
    parameter int unsigned RAMP_STEP = RAMP_STEP_DEF,
    parameter int unsigned DUTY_MAX  = DUTY_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_i,
    input  logic                tick_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    input  logic                period_end_i,
    output logic                pwm_o,
    output logic [PWM_BITS-1:0] duty_o
);

    logic [PWM_BITS-1:0] duty_q,   duty_d;
    logic [PWM_BITS-1:0] shadow_q, shadow_d;
    logic                pwm_q,    pwm_d;

    // Next-state: ramp on tick, latch shadow only at period end, compare against shadow
    always_comb begin
        duty_d   = duty_q;
        shadow_d = shadow_q;
        pwm_d    = (cnt_i < shadow_q);
        if (tick_i) begin
            duty_d = PWM_BITS'(sat_ramp(SAT_W'(duty_q), cmd_i,
                                        SAT_W'(RAMP_STEP), SAT_W'(DUTY_MAX)));
        end
        // Old duty is captured even when a tick lands on the same edge
        if (period_end_i) begin
            shadow_d = duty_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q   <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign duty_o = duty_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Purpose: soft-start/soft-stop PWM driver for the left/right wheel H-bridge enables.
// Ports: clk, reset (sync, active-high), bus (slave): motorLeft/motorRight in,
//        pwmLeft/pwmRight, dutyLeft/dutyRight, brake out (all registered).
module motor_pwm_driver
    import motor_drv_pkg::*;
#(
    parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
    parameter int unsigned RAMP_DIV  = RAMP_DIV_DEF,
    parameter int unsigned RAMP_STEP = RAMP_STEP_DEF,
    parameter int unsigned DUTY_MAX  = DUTY_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    motor_pwm_driver_if.slave  bus
);

    // RAMP_DIV of 1 would give a zero-width counter; keep at least one bit
    localparam int unsigned RCNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PWM_BITS-1:0] cnt_q,  cnt_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic                brake_q, brake_d;
    logic                tick_c;
    logic                period_end_c;
    logic [PWM_BITS-1:0] duty_left, duty_right;
    logic                pwm_left,  pwm_right;

    assign tick_c       = (rcnt_q == RCNT_W'(RAMP_DIV - 1));
    assign period_end_c = (cnt_q == {PWM_BITS{1'b1}});

    // Free-running PWM counter, ramp divider and brake status
    always_comb begin
        cnt_d   = cnt_q + PWM_BITS'(1);
        rcnt_d  = tick_c ? '0 : (rcnt_q + RCNT_W'(1));
        brake_d = !bus.motorLeft && !bus.motorRight
                  && (duty_left == '0) && (duty_right == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            rcnt_q  <= '0;
            brake_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            brake_q <= brake_d;
        end
    end

    pwm_channel #(
        .PWM_BITS  (PWM_BITS),
        .RAMP_STEP (RAMP_STEP),
        .DUTY_MAX  (DUTY_MAX)
    ) u_left (
        .clk          (clk),
        .reset        (reset),
        .cmd_i        (bus.motorLeft),
        .tick_i       (tick_c),
        .cnt_i        (cnt_q),
        .period_end_i (period_end_c),
        .pwm_o        (pwm_left),
        .duty_o       (duty_left)
    );

    pwm_channel #(
        .PWM_BITS  (PWM_BITS),
        .RAMP_STEP (RAMP_STEP),
        .DUTY_MAX  (DUTY_MAX)
    ) u_right (
        .clk          (clk),
        .reset        (reset),
        .cmd_i        (bus.motorRight),
        .tick_i       (tick_c),
        .cnt_i        (cnt_q),
        .period_end_i (period_end_c),
        .pwm_o        (pwm_right),
        .duty_o       (duty_right)
    );

    assign bus.pwmLeft   = pwm_left;
    assign bus.pwmRight  = pwm_right;
    assign bus.dutyLeft  = duty_left;
    assign bus.dutyRight = duty_right;
    assign bus.brake     = brake_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Purpose: directed self-checking bench for motor_pwm_driver
// (PWM_BITS=4, RAMP_DIV=4, RAMP_STEP=4, DUTY_MAX=15).
module tb_motor_pwm_driver;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    motor_pwm_driver_if #(.PWM_BITS(4)) mif ();

    motor_pwm_driver #(
        .PWM_BITS  (4),
        .RAMP_DIV  (4),
        .RAMP_STEP (4),
        .DUTY_MAX  (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Step n rising edges, leaving time 1 unit past the last edge
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 16-edge PWM period; cmds[k] is the left command sampled at the k-th tick in it
    task automatic run_period(input logic [3:0] cmds, output int highs,
                              output int first, output int last, output int r_highs);
        highs = 0; first = -1; last = -1; r_highs = 0;
        for (int j = 1; j <= 16; j++) begin
            mif.motorLeft = cmds[(j - 1) / 4];
            edges(1);
            if (mif.pwmLeft === 1'b1) begin
                highs++;
                if (first < 0) first = j;
                last = j;
            end
            if (mif.pwmRight === 1'b1) r_highs++;
        end
    endtask

    task automatic check_period(input string name, input logic [3:0] cmds,
                                input int exp_highs, input logic [3:0] exp_duty);
        int highs, first, last, r_highs;
        run_period(cmds, highs, first, last, r_highs);
        checks++;
        if (highs !== exp_highs) begin
            errors++;
            $display("FAIL %s highs: got %0d expected %0d", name, highs, exp_highs);
        end
        if (exp_highs > 0) begin
            checks++;
            if (first !== 1 || last !== exp_highs) begin
                errors++;
                $display("FAIL %s shape: high from %0d to %0d expected 1 to %0d",
                         name, first, last, exp_highs);
            end
        end
        checks++;
        if (r_highs !== 0) begin
            errors++;
            $display("FAIL %s right_pwm: got %0d high cycles expected 0", name, r_highs);
        end
        checks++;
        if (mif.dutyLeft !== exp_duty) begin
            errors++;
            $display("FAIL %s duty_end: got %0d expected %0d", name, mif.dutyLeft, exp_duty);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mif.motorLeft = 1'b1;
        mif.motorRight = 1'b1;
        edges(3);
        checks++;
        if ({mif.pwmLeft, mif.pwmRight, mif.brake} !== 3'b000) begin
            errors++;
            $display("FAIL reset_bits: got %b expected 000",
                     {mif.pwmLeft, mif.pwmRight, mif.brake});
        end
        checks++;
        if ({mif.dutyLeft, mif.dutyRight} !== 8'h00) begin
            errors++;
            $display("FAIL reset_duty: got %h expected 00", {mif.dutyLeft, mif.dutyRight});
        end
        reset = 1'b0;
        mif.motorRight = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            edges(1);
            checks++;
            if ({mif.dutyLeft, mif.dutyRight} !== 8'h00) begin
                errors++;
                $display("FAIL pre_tick_duty e%0d: got %h expected 00", e,
                         {mif.dutyLeft, mif.dutyRight});
            end
        end
        edges(1);
        checks++;
        if (mif.dutyLeft !== 4'd4) begin
            errors++;
            $display("FAIL first_tick: got %0d expected 4", mif.dutyLeft);
        end
    endtask

    task automatic test_ramp_up;
        int exp_up [4];
        exp_up = '{8, 12, 15, 15};
        for (int i = 0; i < 4; i++) begin
            edges(4);
            checks++;
            if (mif.dutyLeft !== 4'(exp_up[i])) begin
                errors++;
                $display("FAIL ramp_up e%0d: got %0d expected %0d", 8 + 4 * i,
                         mif.dutyLeft, exp_up[i]);
            end
            checks++;
            if (mif.dutyRight !== 4'd0 || mif.brake !== 1'b0) begin
                errors++;
                $display("FAIL ramp_up_right e%0d: duty %0d brake %b expected 0 0",
                         8 + 4 * i, mif.dutyRight, mif.brake);
            end
        end
    endtask

    task automatic test_ramp_down;
        int exp_dn [4];
        exp_dn = '{11, 7, 3, 0};
        mif.motorLeft = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edges(4);
            checks++;
            if (mif.dutyLeft !== 4'(exp_dn[i])) begin
                errors++;
                $display("FAIL ramp_down e%0d: got %0d expected %0d", 24 + 4 * i,
                         mif.dutyLeft, exp_dn[i]);
            end
        end
        // Brake sees the pre-edge duty, so it rises one edge after duty reaches 0
        checks++;
        if (mif.brake !== 1'b0) begin
            errors++;
            $display("FAIL brake_early: got %b expected 0", mif.brake);
        end
        edges(1);
        checks++;
        if (mif.brake !== 1'b1) begin
            errors++;
            $display("FAIL brake_set: got %b expected 1", mif.brake);
        end
        edges(3);
        checks++;
        if (mif.dutyLeft !== 4'd0 || mif.brake !== 1'b1) begin
            errors++;
            $display("FAIL floor: duty %0d brake %b expected 0 1", mif.dutyLeft, mif.brake);
        end
    endtask

    task automatic test_pwm_shape;
        reset = 1'b1;
        mif.motorLeft = 1'b0;
        mif.motorRight = 1'b0;
        edges(1);
        reset = 1'b0;
        // Shadow is still 0 in the first period; duty climbs to 15
        check_period("p0", 4'b1111, 0, 4'd15);
        // Shadow 12 (duty after 3rd tick); duty falls 15,11,7,3
        check_period("p1", 4'b0001, 12, 4'd3);
        // Shadow 7 while duty moves 0,4,8,12 inside the period
        check_period("p2", 4'b1110, 7, 4'd12);
    endtask

    task automatic test_shadow_glitch_free;
        // Duty was 8 before the period boundary; the coincident tick to 12 is not seen here
        check_period("p3", 4'b0001, 8, 4'd3);
        // Shadow 7 (duty after 15th tick); duty falls to 0
        check_period("p4", 4'b0000, 7, 4'd0);
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        mif.motorLeft = 1'b1;
        edges(12);
        mif.motorLeft = 1'b0;
        edges(4);
        mif.motorLeft = 1'b1;
        edges(5);
        checks++;
        if (mif.dutyLeft !== 4'd12 || mif.pwmLeft !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: duty %0d pwm %b expected 12 1",
                     mif.dutyLeft, mif.pwmLeft);
        end
        reset = 1'b1;
        edges(1);
        checks++;
        if (mif.pwmLeft !== 1'b0 || mif.dutyLeft !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: duty %0d pwm %b expected 0 0",
                     mif.dutyLeft, mif.pwmLeft);
        end
        checks++;
        if (dut.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_cnt: got %0d expected 0", dut.cnt_q);
        end
        reset = 1'b0;
        edges(3);
        checks++;
        if (mif.dutyLeft !== 4'd0) begin
            errors++;
            $display("FAIL restart_hold: got %0d expected 0", mif.dutyLeft);
        end
        edges(1);
        checks++;
        if (mif.dutyLeft !== 4'd4) begin
            errors++;
            $display("FAIL restart_tick: got %0d expected 4", mif.dutyLeft);
        end
    endtask

    initial begin
        reset = 1'b1;
        mif.motorLeft = 1'b0;
        mif.motorRight = 1'b0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_pwm_shape();
        test_shadow_glitch_free();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
